// File: rtl/timer.sv
// Machine timer: 64-bit mtime counter and mtimecmp compare register, 32-bit bus access.
// Ports: clock, reset (async low), read/write bus, registered readData, timer_interrupt.
module timer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] MTIME_ADDR = 32'h0020bff8,
  parameter logic [ADDRESS_BITS-1:0] MTIME_ADDR_H = 32'h0020bffc,
  parameter logic [ADDRESS_BITS-1:0] MTIMECMP_ADDR = 32'h00204000,
  parameter logic [ADDRESS_BITS-1:0] MTIMECMP_ADDR_H = 32'h00204004
) (
  input  logic clock,
  input  logic reset,
  input  logic readEnable,
  input  logic writeEnable,
  input  logic [DATA_WIDTH/8-1:0] writeByteEnable,
  input  logic [ADDRESS_BITS-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic timer_interrupt
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic hitLo;
  logic hitHi;
  logic hitCmpLo;
  logic hitCmpHi;

  assign hitLo = (address == MTIME_ADDR);
  assign hitHi = (address == MTIME_ADDR_H);
  assign hitCmpLo = (address == MTIMECMP_ADDR);
  assign hitCmpHi = (address == MTIMECMP_ADDR_H);

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] data,
    input logic [DATA_WIDTH/8-1:0] be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtime <= '0;
      mtimecmp <= '1;
      readData <= '0;
    end else begin
      // A later mtime write overrides this increment.
      mtime <= mtime + 64'd1;
      if (writeEnable) begin
        unique case (1'b1)
          hitLo:
            mtime <= {mtime[63:32],
              merge(mtime[31:0], writeData, writeByteEnable)};
          hitHi:
            mtime <= {merge(mtime[63:32], writeData, writeByteEnable),
              mtime[31:0]};
          hitCmpLo:
            mtimecmp[31:0] <=
              merge(mtimecmp[31:0], writeData, writeByteEnable);
          hitCmpHi:
            mtimecmp[63:32] <=
              merge(mtimecmp[63:32], writeData, writeByteEnable);
          default: ;
        endcase
      end
      if (readEnable) begin
        unique case (1'b1)
          hitLo: readData <= mtime[31:0];
          hitHi: readData <= mtime[63:32];
          hitCmpLo: readData <= mtimecmp[31:0];
          hitCmpHi: readData <= mtimecmp[63:32];
          default: readData <= '0;
        endcase
      end
    end
  end

  assign timer_interrupt = (mtime >= mtimecmp);

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: arithmetic reference model plus directed vectors.
// Model and pinned literal values are compared against the DUT each cycle.
module tb_timer;

  localparam logic [31:0] A_LO = 32'h0020bff8;
  localparam logic [31:0] A_HI = 32'h0020bffc;
  localparam logic [31:0] A_CLO = 32'h00204000;
  localparam logic [31:0] A_CHI = 32'h00204004;
  localparam logic [31:0] A_BAD = 32'h00200000;

  logic clock = 1'b0;
  logic reset;
  logic readEnable;
  logic writeEnable;
  logic [3:0] writeByteEnable;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic timer_interrupt;

  int checks = 0;
  int failures = 0;

  logic [63:0] mT;
  logic [63:0] mC;
  logic [31:0] mR;

  timer dut (
    .clock(clock),
    .reset(reset),
    .readEnable(readEnable),
    .writeEnable(writeEnable),
    .writeByteEnable(writeByteEnable),
    .address(address),
    .writeData(writeData),
    .readData(readData),
    .timer_interrupt(timer_interrupt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [31:0] old,
    input logic [31:0] d, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (d & m) | (old & ~m);
  endfunction

  // Reference: next state from the pre-edge state and this edge's bus cycle.
  always @(posedge clock or negedge reset) begin
    logic [63:0] t;
    logic [63:0] c;
    if (!reset) begin
      mT <= 64'd0;
      mC <= '1;
      mR <= 32'd0;
    end else begin
      t = mT + 64'd1;
      c = mC;
      if (writeEnable) begin
        if (address == A_LO)
          t = {mT[63:32], lane(mT[31:0], writeData, writeByteEnable)};
        else if (address == A_HI)
          t = {lane(mT[63:32], writeData, writeByteEnable), mT[31:0]};
        else if (address == A_CLO)
          c[31:0] = lane(mC[31:0], writeData, writeByteEnable);
        else if (address == A_CHI)
          c[63:32] = lane(mC[63:32], writeData, writeByteEnable);
      end
      if (readEnable) begin
        if (address == A_LO) mR <= mT[31:0];
        else if (address == A_HI) mR <= mT[63:32];
        else if (address == A_CLO) mR <= mC[31:0];
        else if (address == A_CHI) mR <= mC[63:32];
        else mR <= 32'd0;
      end
      mT <= t;
      mC <= c;
    end
  end

  always @(posedge clock) begin
    #1;
    chk("model_readData", readData, mR);
    chk("model_irq", {31'd0, timer_interrupt}, {31'd0, mT >= mC});
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic op(input logic we, input logic re, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] be);
    writeEnable = we;
    readEnable = re;
    address = a;
    writeData = d;
    writeByteEnable = be;
    tick();
    writeEnable = 1'b0;
    readEnable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    readEnable = 1'b0;
    writeEnable = 1'b0;
    writeByteEnable = 4'h0;
    address = 32'd0;
    writeData = 32'd0;
    repeat (3) @(posedge clock);
    #2;
    chk("reset_readData", readData, 32'd0);
    chk("reset_irq", {31'd0, timer_interrupt}, 32'd0);
    reset = 1'b1;
    repeat (11) tick();
    op(1'b0, 1'b1, A_LO, 32'd0, 4'h0);
    chk("t1_mtime_edge15", readData, 32'd11);

    op(1'b0, 1'b1, A_CLO, 32'd0, 4'h0);
    chk("t2_cmp_lo", readData, 32'hffffffff);
    op(1'b0, 1'b1, A_CHI, 32'd0, 4'h0);
    chk("t2_cmp_hi", readData, 32'hffffffff);
    chk("t2_irq", {31'd0, timer_interrupt}, 32'd0);

    op(1'b1, 1'b0, A_CHI, 32'd0, 4'hf);
    op(1'b1, 1'b0, A_CLO, 32'd20, 4'hf);
    chk("t3_irq_low", {31'd0, timer_interrupt}, 32'd0);
    n = 0;
    while (!timer_interrupt && n < 100) begin
      tick();
      n++;
    end
    chk("t3_irq_rise", {31'd0, timer_interrupt}, 32'd1);
    op(1'b0, 1'b1, A_LO, 32'd0, 4'h0);
    chk("t3_mtime_at_rise", readData, 32'd20);
    op(1'b1, 1'b0, A_CHI, 32'd1, 4'hf);
    chk("t3_irq_drop", {31'd0, timer_interrupt}, 32'd0);

    op(1'b1, 1'b0, A_LO, 32'hfffffffe, 4'hf);
    op(1'b1, 1'b0, A_HI, 32'd0, 4'hf);
    repeat (3) tick();
    op(1'b0, 1'b1, A_HI, 32'd0, 4'h0);
    chk("t4_carry", readData, 32'd1);

    op(1'b1, 1'b0, A_CLO, 32'h11223344, 4'hf);
    op(1'b1, 1'b0, A_CLO, 32'haabbccdd, 4'b0101);
    op(1'b0, 1'b1, A_CLO, 32'd0, 4'h0);
    chk("t5_byte_en", readData, 32'h11bb33dd);
    op(1'b1, 1'b1, A_CLO, 32'h55667788, 4'hf);
    chk("t5_rw_old", readData, 32'h11bb33dd);
    op(1'b0, 1'b1, A_CLO, 32'd0, 4'h0);
    chk("t5_rw_new", readData, 32'h55667788);

    op(1'b1, 1'b0, A_BAD, 32'hdeadbeef, 4'hf);
    op(1'b0, 1'b1, A_BAD, 32'd0, 4'h0);
    chk("t6_unmapped", readData, 32'd0);
    op(1'b0, 1'b1, A_CHI, 32'd0, 4'h0);
    chk("t6_hold_pre", readData, 32'd1);
    repeat (2) tick();
    chk("t6_hold", readData, 32'd1);

    reset = 1'b0;
    #3;
    chk("t6_async_clear", readData, 32'd0);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    op(1'b0, 1'b1, A_LO, 32'd0, 4'h0);
    chk("t6_reset_count", readData, 32'd5);
    op(1'b0, 1'b1, A_CLO, 32'd0, 4'h0);
    chk("t6_reset_cmp", readData, 32'hffffffff);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
